// File: rtl/booth_prod_accum.sv
// Purpose : accumulates a frame of signed 8-bit Booth products into one signed sum.
//           It sends the sum as two bytes, low byte first, and reports signed overflow.
// Latency : the last product is accepted in cycle N; the low byte is valid in cycle N+1.
// Backpr. : prod_ready is low while a result is being sent.
//           The result bytes are held stable until out_ready accepts them.
//
// Ports:
//   clk, rst    : rising-edge clock and asynchronous active-high reset
//   clear       : synchronous frame abort; it has priority over both handshakes
//   len         : terms per frame minus 1; sampled on the first beat of a frame
//   prod_in     : signed product input, with the prod_valid/prod_ready handshake
//   out_byte    : result byte, with the out_valid/out_ready handshake
//   out_last    : high while the high byte is presented
//   ovf         : frame overflow flag, qualified by out_valid
//
// Optional build macro BOOTH_ACC_SAT_EN:
//   defined     -> the accumulator saturates on overflow
//   undefined   -> the accumulator wraps modulo 2^ACC_W
module booth_prod_accum #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_cnt;
    logic        [CNT_W-1:0] r_len_q;
    logic        [15:0]      r_result;
    logic                    r_ovf_q;
    logic                    r_frame_ovf;

    logic signed [ACC_W:0]   w_sum;
    logic                    w_beat_ovf;
    logic                    w_frame_ovf;
    logic signed [ACC_W-1:0] w_new_acc;
    logic                    w_accept;
    logic                    w_last;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The sum has one guard bit, so it never wraps.
    // Overflow shows as the guard bit differing from the accumulator sign bit.
    assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'($signed(prod_in));
    assign w_beat_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    // The first beat of a frame restarts the running overflow flag.
    assign w_frame_ovf = (r_cnt == '0) ? w_beat_ovf : (r_frame_ovf | w_beat_ovf);

`ifdef BOOTH_ACC_SAT_EN
    // On overflow, the guard bit holds the true sign, so it selects the clamp value.
    assign w_new_acc = w_beat_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                  : w_sum[ACC_W-1:0];
`else
    assign w_new_acc = w_sum[ACC_W-1:0];
`endif

    assign w_accept = (r_state == ACCUM) && prod_valid;

    // On the first beat, len_q still holds the previous frame's value.
    // The live len input therefore decides whether this beat is the last.
    assign w_last = (r_cnt == '0) ? (len == '0) : (r_cnt == r_len_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_byte   = 8'h00;
        ovf        = 1'b0;
        case (r_state)
            ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid && w_last) begin
                    w_next = SEND_LO;
                end
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = r_result[7:0];
                ovf       = r_ovf_q;
                if (out_ready) begin
                    w_next = SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_byte  = r_result[15:8];
                out_last  = 1'b1;
                ovf       = r_ovf_q;
                if (out_ready) begin
                    w_next = ACCUM;
                end
            end
            default: w_next = ACCUM;
        endcase
        if (clear) begin
            w_next = ACCUM;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_result    <= '0;
            r_ovf_q     <= 1'b0;
            r_frame_ovf <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_q     <= 1'b0;
            r_frame_ovf <= 1'b0;
        end else if (w_accept) begin
            r_frame_ovf <= w_frame_ovf;
            if (r_cnt == '0) begin
                r_len_q <= len;
            end
            if (w_last) begin
                r_result <= 16'(w_new_acc);
                r_ovf_q  <= w_frame_ovf;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_acc <= w_new_acc;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_booth_prod_accum.sv
module tb_booth_prod_accum;

    localparam int ACC_W = 10;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << (ACC_W-1)) - 1;
    localparam int MINV  = -(1 << (ACC_W-1));
    localparam int RANGE = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [CNT_W-1:0] len;
    logic [7:0]       prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             ovf;

    booth_prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .len        (len),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   frm[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: computes the frame sum and the overflow flag, then queues both expected bytes.
    task automatic model_frame();
        int   acc;
        int   s;
        logic o;
        logic [15:0] r;
        exp_t e;
        acc = 0;
        o   = 1'b0;
        foreach (frm[i]) begin
            s = acc + frm[i];
            if (s > MAXV || s < MINV) o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            if (s > MAXV) s = MAXV;
            else if (s < MINV) s = MINV;
`else
            s = ((s - MINV + 4*RANGE) % RANGE) + MINV;
`endif
            acc = s;
        end
        r = 16'(acc);
        e.b = r[7:0];  e.last = 1'b0; e.ovf = o; sb.push_back(e);
        e.b = r[15:8]; e.last = 1'b1; e.ovf = o; sb.push_back(e);
    endtask

    task automatic send_beat(input logic [7:0] p);
        int n;
        n = 0;
        prod_in    = p;
        prod_valid = 1'b1;
        while (prod_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (prod_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_timeout: prod_ready=%b required 1", prod_ready);
        end
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic send_frame();
        model_frame();
        len = CNT_W'(frm.size() - 1);
        foreach (frm[i]) send_beat(8'(frm[i]));
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency: out_valid=%b required 1 one cycle after last beat", out_valid);
        end
    endtask

    task automatic recv_frame();
        int   n;
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            tests++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                fails++;
                $display("FAIL recv_timeout: out_valid=%b sb=%0d", out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                tests++;
                if (out_byte !== e.b || out_last !== e.last || ovf !== e.ovf || prod_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL recv_byte%0d: byte=%h last=%b ovf=%b prdy=%b required byte=%h last=%b ovf=%b prdy=0",
                             k, out_byte, out_last, ovf, prod_ready, e.b, e.last, e.ovf);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        tests++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL after_send: prod_ready=%b out_valid=%b required 1/0", prod_ready, out_valid);
        end
    endtask

    task automatic run_frame();
        send_frame();
        recv_frame();
    endtask

    task automatic test_reset();
        tests++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_byte !== 8'h00 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: prdy=%b vld=%b last=%b byte=%h ovf=%b required 1 0 0 00 0",
                     prod_ready, out_valid, out_last, out_byte, ovf);
        end
    endtask

    task automatic test_basic();
        frm = '{10, -3, 20};
        run_frame();
        frm = '{-128, -128};
        run_frame();
    endtask

    task automatic test_overflow();
        frm = '{127, 127, 127, 127, 127};
        run_frame();
        // A single-term frame must not inherit the previous frame's overflow flag.
        frm = '{-1};
        run_frame();
    endtask

    task automatic test_backpressure();
        frm = '{10, -3, 20};
        send_frame();
        out_ready  = 1'b0;
        prod_in    = 8'd99;
        prod_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_byte !== 8'h1B || prod_ready !== 1'b0 || out_last !== 1'b0) begin
                fails++;
                $display("FAIL backpressure%0d: vld=%b byte=%h prdy=%b last=%b required 1 1b 0 0",
                         k, out_valid, out_byte, prod_ready, out_last);
            end
            tick();
        end
        prod_valid = 1'b0;
        recv_frame();
        // If the ignored beats had been consumed, this frame's result would be wrong.
        frm = '{5};
        run_frame();
    endtask

    task automatic test_clear();
        len = CNT_W'(2);
        send_beat(8'd10);
        send_beat(8'd20);
        len        = '0;
        prod_in    = 8'd7;
        prod_valid = 1'b1;
        clear      = 1'b1;
        tick();
        clear      = 1'b0;
        prod_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_drop: out_valid=%b prod_ready=%b required 0/1", out_valid, prod_ready);
        end
        frm = '{5};
        run_frame();
    endtask

    task automatic test_rst_mid_send();
        len = '0;
        send_beat(8'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL rst_setup: vld=%b last=%b required 1/1", out_valid, out_last);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: out_valid=%b required 0", out_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: prdy=%b vld=%b required 1/0", prod_ready, out_valid);
        end
        frm = '{3};
        run_frame();
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        len        = '0;
        prod_in    = '0;
        prod_valid = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear();
        test_rst_mid_send();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
